// File: rtl/mat_sparvec_mul_acc.sv
// mat_sparvec_mul_acc: GF(2^8) matrix x sparse-vector multiply with optional
// accumulation into an internal result store (x^8+x^4+x^3+x+1).
//
// Ports:
//   i_clk, i_rst         clock, asynchronous active-low reset
//   i_start, i_accum     start pulse; accum=1 adds onto stored result
//   o_vec_addr, i_vec    sparse entry index / {position, value} (1-cycle read)
//   o_mat_addr, i_mat    column-major matrix word address / data (1-cycle read)
//   i_res_en, i_res_addr result readback request (ignored while busy)
//   o_res                readback data, valid the cycle after the request
//   o_busy, o_done       run in progress / one-cycle completion pulse
//   o_err                sticky: an entry position was out of range
//
// Build option: MAT_SPARVEC_SKIP_ZERO_EN skips the column pass for entries
// whose value is 0x00.
module mat_sparvec_mul_acc #(
    parameter int unsigned MAT_ROW_SIZE_BYTES = 8,
    parameter int unsigned MAT_COL_SIZE_BYTES = 8,
    parameter int unsigned VEC_WEIGHT         = 3,
    parameter int unsigned N_GF               = 8,
    localparam int unsigned PROC_SIZE = N_GF * 8,
    localparam int unsigned W         = (MAT_ROW_SIZE_BYTES + N_GF - 1) / N_GF,
    localparam int unsigned VA_W      = (VEC_WEIGHT > 1) ? $clog2(VEC_WEIGHT) : 1,
    localparam int unsigned POS_W     = (MAT_COL_SIZE_BYTES > 1) ? $clog2(MAT_COL_SIZE_BYTES) : 1,
    localparam int unsigned VEC_W     = POS_W + 8,
    localparam int unsigned MA_W      = (MAT_COL_SIZE_BYTES * W > 1) ? $clog2(MAT_COL_SIZE_BYTES * W) : 1,
    localparam int unsigned RA_W      = (W > 1) ? $clog2(W) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_accum,
    output logic [VA_W-1:0]      o_vec_addr,
    input  logic [VEC_W-1:0]     i_vec,
    output logic [MA_W-1:0]      o_mat_addr,
    input  logic [PROC_SIZE-1:0] i_mat,
    input  logic                 i_res_en,
    input  logic [RA_W-1:0]      i_res_addr,
    output logic [PROC_SIZE-1:0] o_res,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    // Counter covers both the per-column word index and the 2-cycle drain.
    localparam int unsigned CNT_W = RA_W;

    typedef enum logic [2:0] {
        IDLE, CLEAR, VEC_REQ, VEC_WAIT, COL, DRAIN, DONE
    } state_t;

    state_t               state, state_n;
    logic [VA_W-1:0]      k, k_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [7:0]           ent_val, ent_val_n;
    logic                 ent_ok, ent_ok_n;
    logic                 acc_en, acc_en_n;
    logic [CNT_W-1:0]     acc_idx, acc_idx_n;
    logic [VA_W-1:0]      vec_addr_n;
    logic [MA_W-1:0]      mat_addr_n;
    logic                 err_n;
    logic                 clr_en_c;
    logic [POS_W-1:0]     pos_c;
    logic [7:0]           val_c;
    logic                 pos_ok_c;
    logic [PROC_SIZE-1:0] prod_c;
    logic [PROC_SIZE-1:0] rd_c;
    logic [PROC_SIZE-1:0] res_q [W];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    assign pos_c    = i_vec[VEC_W-1:8];
    assign val_c    = i_vec[7:0];
    assign pos_ok_c = (32'(pos_c) < MAT_COL_SIZE_BYTES);

    // State register and registered outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= IDLE;
            k          <= '0;
            cnt        <= '0;
            ent_val    <= '0;
            ent_ok     <= 1'b0;
            acc_en     <= 1'b0;
            acc_idx    <= '0;
            o_vec_addr <= '0;
            o_mat_addr <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_res      <= '0;
        end else begin
            state      <= state_n;
            k          <= k_n;
            cnt        <= cnt_n;
            ent_val    <= ent_val_n;
            ent_ok     <= ent_ok_n;
            acc_en     <= acc_en_n;
            acc_idx    <= acc_idx_n;
            o_vec_addr <= vec_addr_n;
            o_mat_addr <= mat_addr_n;
            o_busy     <= (state_n != IDLE);
            o_done     <= (state_n == DONE);
            o_err      <= err_n;
            if (!o_busy && i_res_en) o_res <= rd_c;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_n    = state;
        k_n        = k;
        cnt_n      = cnt;
        ent_val_n  = ent_val;
        ent_ok_n   = ent_ok;
        acc_en_n   = 1'b0;
        acc_idx_n  = acc_idx;
        vec_addr_n = o_vec_addr;
        mat_addr_n = o_mat_addr;
        err_n      = o_err;
        clr_en_c   = 1'b0;

        case (state)
            IDLE: begin
                if (i_start) begin
                    err_n      = 1'b0;
                    k_n        = '0;
                    cnt_n      = '0;
                    vec_addr_n = '0;
                    state_n    = i_accum ? VEC_REQ : CLEAR;
                end
            end
            CLEAR: begin
                clr_en_c = 1'b1;
                if (32'(cnt) == W - 1) begin
                    cnt_n   = '0;
                    state_n = VEC_REQ;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            VEC_REQ: begin
                state_n = VEC_WAIT;
            end
            VEC_WAIT: begin
                // Out-of-range entries still walk the column but never write.
                ent_val_n  = val_c;
                ent_ok_n   = pos_ok_c;
                if (!pos_ok_c) err_n = 1'b1;
                mat_addr_n = pos_ok_c ? MA_W'(32'(pos_c) * W) : '0;
                cnt_n      = '0;
                state_n    = COL;
`ifdef MAT_SPARVEC_SKIP_ZERO_EN
                if (val_c == 8'h00) begin
                    if (32'(k) == VEC_WEIGHT - 1) begin
                        state_n = DRAIN;
                    end else begin
                        k_n        = k + VA_W'(1);
                        vec_addr_n = k + VA_W'(1);
                        state_n    = VEC_REQ;
                    end
                end
`endif
            end
            COL: begin
                // Word issued now is accumulated one cycle later.
                acc_en_n  = ent_ok;
                acc_idx_n = cnt;
                if (32'(cnt) == W - 1) begin
                    cnt_n = '0;
                    if (32'(k) == VEC_WEIGHT - 1) begin
                        state_n = DRAIN;
                    end else begin
                        k_n        = k + VA_W'(1);
                        vec_addr_n = k + VA_W'(1);
                        state_n    = VEC_REQ;
                    end
                end else begin
                    cnt_n      = cnt + CNT_W'(1);
                    mat_addr_n = o_mat_addr + MA_W'(1);
                end
            end
            DRAIN: begin
                if (cnt == CNT_W'(1)) begin
                    cnt_n   = '0;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Per-byte GF products; padding rows beyond the matrix height contribute 0.
    always_comb begin
        prod_c = '0;
        for (int unsigned j = 0; j < N_GF; j++) begin
            if (32'(acc_idx) * N_GF + j < MAT_ROW_SIZE_BYTES) begin
                prod_c[j*8 +: 8] = gf_mul(i_mat[j*8 +: 8], ent_val);
            end
        end
    end

    // Readback mux
    always_comb begin
        rd_c = '0;
        for (int unsigned w = 0; w < W; w++) begin
            if (32'(i_res_addr) == w) rd_c = res_q[w];
        end
    end

    // Result store: clear or read-modify-write, no reset (contents undefined).
    always_ff @(posedge i_clk) begin
        for (int unsigned w = 0; w < W; w++) begin
            if (clr_en_c && 32'(cnt) == w) begin
                res_q[w] <= '0;
            end else if (acc_en && 32'(acc_idx) == w) begin
                res_q[w] <= res_q[w] ^ prod_c;
            end
        end
    end

endmodule

// File: tb/tb_mat_sparvec_mul_acc.sv
// Directed bench for mat_sparvec_mul_acc. A second instance with 9 columns
// provides position encodings that can exceed the column count.
module tb_mat_sparvec_mul_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start9 = 1'b0;
    logic        acc = 1'b0;
    logic        res_en = 1'b0;
    logic [0:0]  res_addr = 1'b0;

    logic [1:0]  vec_addr, vec_addr9;
    logic [2:0]  mat_addr;
    logic [3:0]  mat_addr9;
    logic [10:0] vec_q;
    logic [11:0] vec_q9;
    logic [63:0] mat_q, mat_q9;
    logic [63:0] res, res9;
    logic        busy, done, err, busy9, done9, err9;

    logic [10:0] vec_mem  [0:3];
    logic [63:0] mat_mem  [0:7];
    logic [11:0] vec_mem9 [0:3];
    logic [63:0] mat_mem9 [0:15];

    int vectors = 0;
    int fails   = 0;
    int lat;
    logic [63:0] rd;

    always #5 clk = ~clk;

    mat_sparvec_mul_acc u_dut (
        .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_accum(acc),
        .o_vec_addr(vec_addr), .i_vec(vec_q), .o_mat_addr(mat_addr), .i_mat(mat_q),
        .i_res_en(res_en), .i_res_addr(res_addr), .o_res(res),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    mat_sparvec_mul_acc #(.MAT_COL_SIZE_BYTES(9)) u_dut9 (
        .i_clk(clk), .i_rst(rst_n), .i_start(start9), .i_accum(acc),
        .o_vec_addr(vec_addr9), .i_vec(vec_q9), .o_mat_addr(mat_addr9), .i_mat(mat_q9),
        .i_res_en(res_en), .i_res_addr(res_addr), .o_res(res9),
        .o_busy(busy9), .o_done(done9), .o_err(err9)
    );

    // Memories with one-cycle registered read latency
    always @(posedge clk) begin
        vec_q  <= vec_mem[vec_addr];
        mat_q  <= mat_mem[mat_addr];
        vec_q9 <= vec_mem9[vec_addr9];
        mat_q9 <= mat_mem9[mat_addr9];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start a run on the selected instance and count cycles to o_done.
    task automatic run(input bit sel, input bit accum, input bit pulse_mid, output int n);
        @(negedge clk);
        if (sel) start9 = 1'b1; else start = 1'b1;
        acc = accum;
        @(posedge clk); #1;
        start = 1'b0; start9 = 1'b0;
        check("busy_after_start", sel ? busy9 : busy, 1);
        check("err_cleared_on_start", sel ? err9 : err, 0);
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            start = pulse_mid && (n == 4);
            if (sel ? done9 : done) break;
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("done_one_cycle", sel ? done9 : done, 0);
        check("idle_after_done", sel ? busy9 : busy, 0);
    endtask

    task automatic read_res(input bit sel, output logic [63:0] data);
        @(negedge clk);
        res_en = 1'b1;
        res_addr = 1'b0;
        @(posedge clk); #1;
        res_en = 1'b0;
        data = sel ? res9 : res;
    endtask

    initial begin
        for (int p = 0; p < 8; p++) mat_mem[p] = 64'h1 << (8 * p);
        for (int p = 0; p < 16; p++) mat_mem9[p] = (p < 8) ? (64'h1 << (8 * p)) : {64{1'b1}};
        vec_mem[3]  = '0;
        vec_mem9[3] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_res", res, 0);
        check("rst_vec_addr", 64'(vec_addr), 0);
        check("rst_mat_addr", 64'(mat_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a column pass
        vec_mem[0] = {3'd2, 8'h05};
        vec_mem[1] = {3'd5, 8'h80};
        vec_mem[2] = {3'd7, 8'h01};
        @(negedge clk);
        start = 1'b1; acc = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_err", err, 0);
        check("midrst_mat_addr", 64'(mat_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Identity matrix, three entries, clear first
        run(1'b0, 1'b0, 1'b0, lat);
        check("ident_latency", 64'(lat), 12);
        check("ident_err", err, 0);
        read_res(1'b0, rd);
        check("ident_res", rd, 64'h01_00_80_00_00_05_00_00);
        @(posedge clk); #1;
        check("res_holds", res, 64'h01_00_80_00_00_05_00_00);

        // Same entries accumulated onto themselves cancel; mid-run start ignored
        run(1'b0, 1'b1, 1'b1, lat);
        check("accum_latency", 64'(lat), 11);
        read_res(1'b0, rd);
        check("accum_res", rd, 64'h0);

        // Duplicate positions: three equal terms XOR to one
        mat_mem[0] = {8{8'h80}};
        vec_mem[0] = {3'd0, 8'h02};
        vec_mem[1] = {3'd0, 8'h02};
        vec_mem[2] = {3'd0, 8'h02};
        run(1'b0, 1'b0, 1'b0, lat);
        check("dup_latency", 64'(lat), 12);
        read_res(1'b0, rd);
        check("dup_res", rd, {8{8'h1B}});
        mat_mem[0] = 64'h1;

        // Zero-value entries
        vec_mem[0] = {3'd1, 8'h00};
        vec_mem[1] = {3'd2, 8'h00};
        vec_mem[2] = {3'd3, 8'h07};
        run(1'b0, 1'b0, 1'b0, lat);
`ifdef MAT_SPARVEC_SKIP_ZERO_EN
        check("zero_latency", 64'(lat), 10);
`else
        check("zero_latency", 64'(lat), 12);
`endif
        read_res(1'b0, rd);
        check("zero_res", rd, 64'h00000000_07000000);

        // Out-of-range position on the 9-column instance
        vec_mem9[0] = {4'd1, 8'h02};
        vec_mem9[1] = {4'd9, 8'h33};
        vec_mem9[2] = {4'd3, 8'h01};
        run(1'b1, 1'b0, 1'b0, lat);
        check("poserr_latency", 64'(lat), 12);
        check("poserr_err", err9, 1);
        read_res(1'b1, rd);
        check("poserr_res", rd, 64'h00000000_01000200);

        // Next start clears the error; column 8 pads rows beyond none
        vec_mem9[0] = {4'd0, 8'h01};
        vec_mem9[1] = {4'd0, 8'h01};
        vec_mem9[2] = {4'd0, 8'h01};
        run(1'b1, 1'b0, 1'b0, lat);
        check("clr_latency", 64'(lat), 12);
        check("clr_err", err9, 0);
        read_res(1'b1, rd);
        check("clr_res", rd, 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/mat_sparvec_mul_acc.md
MAT_SPARVEC_MUL_ACC -- requirements
Module: mat_sparvec_mul_acc

Interface
REQ-001 SHALL have parameter MAT_ROW_SIZE_BYTES, default 8: result length in GF(2^8) bytes (matrix rows).
REQ-002 SHALL have parameter MAT_COL_SIZE_BYTES, default 8: matrix columns; equals dense vector length VEC_SIZE_BYTES.
REQ-003 SHALL have parameter VEC_WEIGHT, default 3: number of sparse entries, >=1.
REQ-004 SHALL have parameter N_GF, default 8: bytes per datapath word, 1..32; PROC_SIZE=N_GF*8, W=ceil(MAT_ROW_SIZE_BYTES/N_GF).
REQ-005 SHALL have ports i_clk in 1 (sole clock); i_rst in 1 (asynchronous, active-low reset).
REQ-006 SHALL have ports i_start in 1 (start pulse); i_accum in 1 (sampled with i_start: 1=add onto stored result, 0=clear first).
REQ-007 SHALL have ports o_vec_addr out CLOG2(VEC_WEIGHT) (sparse entry index); i_vec in CLOG2(MAT_COL_SIZE_BYTES)+8 ({position, value}, value in low 8 bits).
REQ-008 SHALL have ports o_mat_addr out CLOG2(MAT_COL_SIZE_BYTES*W) (word address); i_mat in PROC_SIZE (matrix word).
REQ-009 SHALL have ports i_res_en in 1, i_res_addr in CLOG2(W), o_res out PROC_SIZE (result readback).
REQ-010 SHALL have ports o_busy out 1; o_done out 1 (one-cycle pulse); o_err out 1 (sticky position error).

Function
REQ-011 SHALL compute res = res_prev(if accum) XOR sum over entries k of val_k * column(pos_k), GF(2^8) with polynomial x^8+x^4+x^3+x+1.
REQ-012 SHALL treat matrix as column-major: column p at words p*W..p*W+W-1; byte j of word = row (word*N_GF+j), byte 0 in bits [7:0]; padding bytes of last word ignored and stored as 0.
REQ-013 SHALL assume both memories have exactly one-cycle registered read latency.
REQ-014 SHALL hold result in an internal W x PROC_SIZE register/RAM updated by read-modify-write, N_GF parallel GF multipliers.
REQ-015 SHALL implement states IDLE, CLEAR, VEC_REQ, VEC_WAIT, COL, DRAIN, DONE.
REQ-016 IDLE: i_start=1 -> CLEAR if i_accum=0 else VEC_REQ; o_busy=1 from next cycle until DONE exits.
REQ-017 CLEAR: zero one result word per cycle, W cycles, -> VEC_REQ.
REQ-018 VEC_REQ drives o_vec_addr=k (1 cycle); VEC_WAIT latches entry (1 cycle); COL issues W consecutive matrix addresses (W cycles), accumulating each word one cycle after issue.
REQ-019 After COL, next entry -> VEC_REQ (k+1); after entry VEC_WEIGHT-1 -> DRAIN (2 cycles) -> DONE (o_done=1 for 1 cycle) -> IDLE.
REQ-020 Start-to-done latency SHALL be exactly (i_accum?0:W) + VEC_WEIGHT*(W+2) + 2 cycles, i_start edge counted as cycle 0.
REQ-021 Entry with pos >= MAT_COL_SIZE_BYTES SHALL be skipped (no result change, still W+2 cycles), o_err set; o_err cleared only by next accepted i_start or reset.
REQ-022 Duplicate positions SHALL accumulate (XOR) normally.
REQ-023 i_start while o_busy=1 SHALL be ignored.
REQ-024 Readback: when o_busy=0 and i_res_en=1, o_res = result word i_res_addr on next cycle; otherwise o_res holds; i_res_en while busy ignored.

Reset
REQ-025 i_rst=0 SHALL asynchronously force IDLE, o_busy=0, o_done=0, o_err=0, o_res=0, o_vec_addr=0, o_mat_addr=0, including mid-operation.
REQ-026 Result storage SHALL be undefined after reset until a run with i_accum=0 completes.

Configuration
REQ-027 Macro MAT_SPARVEC_SKIP_ZERO_EN defined: entry with value 0x00 SHALL skip COL (VEC_REQ, VEC_WAIT only, 2 cycles), latency reduced by W per zero entry.
REQ-028 Macro undefined: zero-value entries SHALL take full W+2 cycles, result unchanged; REQ-020 exact.

Verification (defaults, W=1)
REQ-029 Reset mid-COL -> o_busy=0, o_done=0, o_err=0 same cycle; new start with i_accum=0 completes correctly.
REQ-030 Identity 8x8 matrix, entries {2,0x05},{5,0x80},{7,0x01}, accum=0 -> o_res=0x01_00_80_00_00_05_00_00 ({byte7..byte0}), done 12 cycles after start.
REQ-031 Column 0 all 0x80, entry {0,0x02} x3, accum=0 -> each byte 0x1B (three equal terms XOR to one), latency 12.
REQ-032 Repeat REQ-030 with accum=1 -> o_res=0, latency 11; i_start pulsed mid-run ignored.
REQ-033 Entry {9,0x33} -> o_err=1 at done, that entry contributes nothing; cleared on next start.
REQ-034 With MAT_SPARVEC_SKIP_ZERO_EN, entries {1,0x00},{2,0x00},{3,0x07} -> latency 10, result = 0x07*column 3.
